// File: rtl/fir_pkg.sv
// fir_pkg: shared sample/frame geometry for the packer and the decimating FIR.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fir_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int CHANNELS    = 2;   // only 2 is supported
  localparam int P_SAMPLES   = 8;   // power of two, >= 2
  localparam int FRAME_WIDTH = CHANNELS * P_SAMPLES * DATA_WIDTH;
  localparam int HALF_WIDTH  = P_SAMPLES * DATA_WIDTH;
  localparam int CNT_W       = $clog2(P_SAMPLES);

  typedef logic signed [DATA_WIDTH-1:0]  sample_t;
  typedef logic        [FRAME_WIDTH-1:0] frame_t;

endpackage

// File: rtl/sample_packer.sv
// sample_packer: packs P_SAMPLES two-channel beats into one FIR frame, newest sample in lane 0.
// Latency: frame valid the cycle after its completing beat is accepted.
// Backpressure: only a frame-completing beat stalls, and only while the output slot is full and not draining.
//
// Ports:
//   clk, nrst           single rising-edge clock, async active-low reset
//   s_tvalid/s_tready   input beat handshake; s_tdata[15:0]=CH0, [31:16]=CH1
//   s_tlast             only with SAMPLE_PACKER_TLAST_EN: closes the frame early, unwritten lanes zero
//   m_tvalid/m_tready   output frame handshake; m_tdata CH0 lanes in [127:0], CH1 lanes in [255:128]
// Optional feature macro: SAMPLE_PACKER_TLAST_EN
module sample_packer
  import fir_pkg::*;
(
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             s_tvalid,
  output logic                             s_tready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   s_tdata,
`ifdef SAMPLE_PACKER_TLAST_EN
  input  logic                             s_tlast,
`endif
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output frame_t                           m_tdata
);

  logic             r_rdy_en;
  logic [CNT_W-1:0] r_cnt;
  frame_t           r_fill;
  frame_t           r_out;
  logic             r_out_vld;

  logic                 w_close;
  logic                 w_accept;
  logic                 w_complete;
  logic [CNT_W-1:0]     w_lane;
  logic [P_SAMPLES-1:0] w_wr;
  frame_t               w_fill_next;
  frame_t               w_frame;

`ifdef SAMPLE_PACKER_TLAST_EN
  assign w_close = (r_cnt == CNT_W'(P_SAMPLES-1)) || s_tlast;
`else
  assign w_close = (r_cnt == CNT_W'(P_SAMPLES-1));
`endif

  // m_tready reaches s_tready combinationally so a draining slot can take a completing beat.
  assign s_tready   = r_rdy_en && !(w_close && r_out_vld && !m_tready);
  assign w_accept   = s_tvalid && s_tready;
  assign w_complete = w_accept && w_close;

  // First beat of a frame lands in the top (oldest) lane, counting down to lane 0.
  assign w_lane = CNT_W'(P_SAMPLES-1) - r_cnt;

  for (genvar j = 0; j < P_SAMPLES; j++) begin : g_lane
    assign w_wr[j] = w_accept && (w_lane == CNT_W'(j));
    assign w_fill_next[j*DATA_WIDTH +: DATA_WIDTH] =
      w_wr[j] ? s_tdata[DATA_WIDTH-1:0] : r_fill[j*DATA_WIDTH +: DATA_WIDTH];
    assign w_fill_next[HALF_WIDTH + j*DATA_WIDTH +: DATA_WIDTH] =
      w_wr[j] ? s_tdata[2*DATA_WIDTH-1:DATA_WIDTH] : r_fill[HALF_WIDTH + j*DATA_WIDTH +: DATA_WIDTH];
`ifdef SAMPLE_PACKER_TLAST_EN
    // Lanes below the last-written lane still hold the previous frame; blank them on an early close.
    assign w_frame[j*DATA_WIDTH +: DATA_WIDTH] =
      (CNT_W'(j) >= w_lane) ? w_fill_next[j*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign w_frame[HALF_WIDTH + j*DATA_WIDTH +: DATA_WIDTH] =
      (CNT_W'(j) >= w_lane) ? w_fill_next[HALF_WIDTH + j*DATA_WIDTH +: DATA_WIDTH] : '0;
`endif
  end

`ifndef SAMPLE_PACKER_TLAST_EN
  assign w_frame = w_fill_next;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rdy_en  <= 1'b0;
      r_cnt     <= '0;
      r_fill    <= '0;
      r_out     <= '0;
      r_out_vld <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_accept) begin
        r_fill <= w_fill_next;
        r_cnt  <= w_complete ? '0 : r_cnt + 1'b1;
      end
      // A completion on the draining edge reloads the slot, so valid never dips.
      if (w_complete) begin
        r_out     <= w_frame;
        r_out_vld <= 1'b1;
      end else if (m_tready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign m_tvalid = r_out_vld;
  assign m_tdata  = r_out;

endmodule

// File: doc/sample_packer.md
# sample_packer

Serial-to-parallel front end for the dual-channel decimating FIR. Accepts one two-channel sample per beat on an AXI-Stream-style slave port and packs eight consecutive beats into the 256-bit frame the FIR consumes. CH0 samples are packed into bits [127:0] and CH1 samples into bits [255:128], newest sample in lane 0. A double-buffered output register allows continuous input at one beat per clock while a completed frame waits for `m_tready`.

## Interface
- `DATA_WIDTH`, 16: bits per sample per channel.
- `CHANNELS`, 2: channel count. Only 2 is supported.
- `P_SAMPLES`, 8: beats packed per output frame. Must be a power of two, ≥2.
- `clk` in 1: single clock; all logic is on the rising edge.
- `nrst` in 1: reset, asynchronous assert, active-low.
- `s_tvalid` in 1: input beat valid.
- `s_tready` out 1: input beat accepted when `s_tvalid && s_tready`.
- `s_tdata` in CHANNELS*DATA_WIDTH: [15:0] = CH0 sample, [31:16] = CH1 sample.
- `s_tlast` in 1: present only with `SAMPLE_PACKER_TLAST_EN`; closes the current frame early.
- `m_tvalid` out 1: packed frame valid. Held until accepted.
- `m_tready` in 1: downstream ready.
- `m_tdata` out CHANNELS*P_SAMPLES*DATA_WIDTH: CH0 lane j at [j*16 +: 16]; CH1 lane j at [128 + j*16 +: 16].

## Operation
- **Fill buffer:** `fill_q`, 256 bits, plus lane counter `cnt` in 0..P_SAMPLES-1.
- **Beat write:** an accepted beat writes CH0 to lane (P_SAMPLES-1-cnt) of the CH0 half and CH1 to the same lane of the CH1 half, then `cnt` increments.
  - The first beat of a frame lands in lane 7 (oldest); the eighth lands in lane 0 (newest).
  - This matches the FIR tap order, where tap 0 is the newest sample.
- **Frame complete:** the accept with `cnt == P_SAMPLES-1` completes the frame.
  - `m_tdata` is loaded with the completed fill contents, including the beat just accepted.
  - `m_tvalid` is set and `cnt` returns to 0 in the same edge.
- **Output slot:** `out_valid` (= `m_tvalid`) is cleared on `m_tvalid && m_tready` unless a new frame completes on the same edge. In that case the slot reloads and stays valid.
- **Backpressure:** s_tready = rdy_en && !(cnt == P_SAMPLES-1 && out_valid && !m_tready).
  - A completing beat is never accepted while the slot is full and not draining.
  - Beats 0..6 of the next frame are always accepted.
  - The path `m_tready` → `s_tready` is combinational by design.
- **rdy_en:** a flop cleared by reset, set to 1 on the first clock after `nrst` deasserts.
- **No data arithmetic:** samples pass bit-exact, with no sign handling or width change.
- **Reset mid-frame:** the partial frame is discarded, `cnt` goes to 0 and `out_valid` to 0. No partial frame is ever emitted.

## Timing
- **Reset values:** `s_tready`=0, `m_tvalid`=0, `m_tdata`=0. All state registers are 0.
- **First ready:** `s_tready` rises on the first rising edge after `nrst` goes high.
- **Latency:** if the completing beat is accepted at edge N, `m_tvalid`=1 with the new `m_tdata` after edge N.
- **Throughput:** one frame per P_SAMPLES accepted beats. Sustained `s_tvalid`=1 with `m_tready`=1 gives zero stall cycles.
- **m_tdata stability:** `m_tdata` holds while `m_tvalid && !m_tready`. Fill-buffer writes never disturb it.
- **Simultaneous drain and complete:** `m_tvalid` stays 1 and `m_tdata` updates to the new frame on that edge.
- **Idle:** no `s_tvalid` means no state change. Gaps between beats are allowed at any lane.

## Configuration
- **Macro:** `SAMPLE_PACKER_TLAST_EN`.
- **Defined:** the `s_tlast` port exists.
  - An accepted beat with `s_tlast`=1 completes the frame regardless of `cnt`.
  - Lanes not yet written (lanes below the last-written lane) are zero-filled in `m_tdata`.
  - The acceptance rule treats a `s_tlast` beat exactly like cnt == P_SAMPLES-1: it needs the slot empty or draining.
- **Undefined:** no `s_tlast` port. Frames complete only on the P_SAMPLES-th beat.

## Structure
- **Shared package `fir_pkg`:** parameters `DATA_WIDTH`, `CHANNELS`, `P_SAMPLES`, and derived `FRAME_WIDTH` = CHANNELS*P_SAMPLES*DATA_WIDTH.
  - Typedefs `sample_t` (signed [DATA_WIDTH-1:0]) and `frame_t` ([FRAME_WIDTH-1:0]).
  - The FIR imports the same package.
- **No sub-module:** single module. The lane write is a generate loop over `P_SAMPLES`.

## Test plan
- **Reset release:** hold `nrst`=0 for 5 clocks, drive `s_tvalid`=1 → `s_tready`=0 and `m_tvalid`=0 throughout. `s_tready`=1 one edge after release.
- **Basic pack:** 8 beats, CH0=0x0001..0x0008, CH1=0x1001..0x1008, `m_tready`=1 → after the 8th beat:
  - `m_tdata[15:0]`=0x0008, `[127:112]`=0x0001, `[143:128]`=0x1008, `[255:240]`=0x1001.
  - `m_tvalid` high exactly 1 cycle.
- **Continuous streaming:** 64 beats back-to-back with `m_tready`=1 → 8 frames, one every 8 cycles, `s_tready` never low. Contents match a reference model.
- **Backpressure:** `m_tready`=0 while 16 beats are offered → first frame held stable, `s_tready`=0 only at the 16th beat. Raise `m_tready` → frame 1 drains and frame 2 loads on the same edge.
- **Reset mid-frame:** assert `nrst` after 5 beats, release, send 8 beats 0xA0..0xA7 → only one frame, containing 0xA0..0xA7. No stale data.
- **`SAMPLE_PACKER_TLAST_EN`:** 3 beats CH0=0x11, 0x22, 0x33, with `s_tlast` on the third → lanes 7, 6, 5 = 0x11, 0x22, 0x33. Lanes 4..0 = 0 in both channels.
